// File: rtl/mtx_uart_pkg.sv
// mtx_uart_pkg
//   Types and constants shared by the MTX512 host-link UART transmitter and
//   receiver.
//
//   uart_tx_state_t : transmit FSM states. PARITY exists only when the
//                     MTX_UART_TX_PARITY_EN macro is defined.
//   UART_DATA_BITS  : data bits per frame.
//   UART_IDLE_LEVEL : line level between frames (mark).
package mtx_uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef MTX_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;

endpackage : mtx_uart_pkg

// File: rtl/mtx_uart_fifo.sv
// mtx_uart_fifo
//   Synchronous FIFO buffering bytes ahead of the UART transmitter.
//   First-word fall-through: rd_data always shows the oldest entry.
//
//   Parameters : FIFO_DEPTH (power of two, 2..256), WIDTH (entry width).
//   Ports      : clk_sys, reset_n (async, active low)
//                push/wr_data  - enqueue; ignored while full
//                pop/rd_data   - dequeue; ignored while empty
//                full, empty   - registered occupancy flags
//                count         - occupancy, log2(FIFO_DEPTH)+1 bits
module mtx_uart_fifo #(
  parameter  int FIFO_DEPTH = 16,
  parameter  int WIDTH      = 8,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  // A write while full is dropped even if a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_d = count;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, so resetting them would only add reset fan-out.
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(FIFO_DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule : mtx_uart_fifo

// File: rtl/mtx_uart_tx.sv
// mtx_uart_tx
//   Host-link serial transmitter driving the board UART_TX pin. Bytes are
//   queued in mtx_uart_fifo and sent as start, 8 data bits LSB first,
//   optional parity, one stop bit. Bit period is (div+1) clocks; div is
//   latched when a byte is popped so mid-frame changes apply to the next frame.
//
//   Build option: define MTX_UART_TX_PARITY_EN to add the PARITY state and
//   the parity_odd port (parity_odd=0 gives even parity).
//
//   Ports: clk_sys, reset_n (async, active low)
//          div        - clocks per bit minus one
//          wr_en/wr_data - queue one byte per cycle
//          full/empty - FIFO status; busy - frame in progress
//          overflow   - sticky, set by a write while full; ovf_clr clears
//          tx         - serial line, idle high
//          parity_odd - parity sense (parity builds only)
module mtx_uart_tx
  import mtx_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             tx
`ifdef MTX_UART_TX_PARITY_EN
  ,
  input  logic             parity_odd
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t      state_q, state_d;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          idx_q, idx_d;
  logic                tx_d;
  logic                pop;
  logic                bit_done;
  logic [7:0]          fifo_rd_data;
  logic [CNT_W-1:0]    fifo_count;
`ifdef MTX_UART_TX_PARITY_EN
  logic                par_q;
`endif

  mtx_uart_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (UART_DATA_BITS)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign bit_done = (cnt_q == '0);

  // NOTE: every signal is given a default before the case so no path leaves
  // it unassigned; this keeps the block purely combinational (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;

    // Every non-idle state shares one bit-period counter: reload from the
    // latched divisor when a bit ends, otherwise count down.
    if (state_q != IDLE) begin
      cnt_d = bit_done ? div_q : cnt_q - DIV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          cnt_d   = div;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef MTX_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef MTX_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // tx is registered, so it is decoded from the next state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef MTX_UART_TX_PARITY_EN
      PARITY:  tx_d = par_q ^ parity_odd;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      tx       <= UART_IDLE_LEVEL;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx      <= tx_d;
      busy    <= (state_d != IDLE);
      if (pop) div_q <= div;
      // Set has priority over clear.
      if (wr_en && full) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

`ifdef MTX_UART_TX_PARITY_EN
  // Parity of the popped byte, captured before the shift register consumes it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)  par_q <= 1'b0;
    else if (pop)  par_q <= ^fifo_rd_data;
  end
`endif

endmodule : mtx_uart_tx
